// File: rtl/dfp_line_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dfp_line_responder_if
// Brief    : Line-granular dfp request/response bundle (initiator <-> memory).
// Revision : 1.0
// ============================================================================
interface dfp_line_responder_if #(
  parameter int CACHELINE = 64
);
  logic [31:0]          dfp_addr;
  logic                 dfp_read;
  logic                 dfp_write;
  logic [CACHELINE-1:0] dfp_wdata;
  logic [CACHELINE-1:0] dfp_rdata;
  logic                 dfp_resp;

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp
  );

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp
  );
endinterface
`default_nettype wire

// File: rtl/dfp_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : dfp_line_responder
// Brief    : Single-outstanding cacheline memory with fixed response latency.
// Revision : 1.0
// ============================================================================
module dfp_line_responder #(
  parameter int LINES     = 256,
  parameter int CACHELINE = 64,
  parameter int LATENCY   = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  dfp_line_responder_if.slave  dfp
);
  localparam int IDX_W = $clog2(LINES);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  localparam logic [7:0] c_LAT  = 8'(LATENCY);

  logic [1:0]           r_state;
  logic [7:0]           r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_write;
  logic [CACHELINE-1:0] r_wdata;
  logic [CACHELINE-1:0] r_rdata;
  logic                 r_resp;
  logic [CACHELINE-1:0] r_store [LINES];

  logic [IDX_W-1:0]     w_req_idx;
  logic                 w_unused;

  assign w_req_idx = dfp.dfp_addr[3 +: IDX_W];
  assign w_unused  = ^dfp.dfp_addr;

  assign dfp.dfp_resp  = r_resp;
  assign dfp.dfp_rdata = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_resp  <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        r_store[i] <= '0;
      end
    end else begin
      case (r_state)
        c_IDLE: begin
          if (dfp.dfp_read || dfp.dfp_write) begin
            r_idx   <= w_req_idx;
            r_write <= dfp.dfp_write;
            r_wdata <= dfp.dfp_wdata;
            r_cnt   <= c_LAT;
            if (LATENCY > 0) begin
              r_state <= c_WAIT;
            end else begin
              // Zero latency: response data comes straight from the request index.
              r_state <= c_RESP;
              r_resp  <= 1'b1;
              r_rdata <= dfp.dfp_write ? '0 : r_store[w_req_idx];
            end
          end
        end
        c_WAIT: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_state <= c_RESP;
            r_resp  <= 1'b1;
            r_rdata <= r_write ? '0 : r_store[r_idx];
          end
        end
        c_RESP: begin
          r_resp  <= 1'b0;
          r_rdata <= '0;
          if (r_write) begin
            r_store[r_idx] <= r_wdata;
          end
          r_state <= c_DONE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire
